mem_port_arbiter: RTL and testbench

Arbitrates a single-ported unified 16-bit memory between the CPU instruction-fetch path and the LDR/STR data path, sequencing one memory transaction at a time.
- Each requester holds its request until the arbiter grants it; the arbiter then drives the memory until `mem_ready`, and pulses a completion strobe with read data.
- Data accesses have priority, bounded by an anti-starvation counter that guarantees fetch progress.
- Sits between the core (fetch unit, `MemRead`/`MemWrite` decode) and the memory model.

---
 rtl/mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch path
// and the load/store data path. Only one memory transaction is in flight at a
// time. Data accesses normally win ties, and a streak counter lets a waiting
// fetch through after STARVE_LIMIT consecutive data grants.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   reset      : asynchronous, active-low (0 = in reset)
//   if_req     : fetch request, held until if_done
//   if_addr    : fetch address, stable while if_req
//   if_gnt     : 1-cycle pulse, fetch transaction launched
//   if_done    : 1-cycle pulse, if_rdata valid
//   if_rdata   : last fetched word, held until the next fetch completion
//   d_req      : data request, held until d_done
//   d_we       : 1 = store, 0 = load
//   d_addr     : data address
//   d_wdata    : store data
//   d_gnt      : 1-cycle pulse, data transaction launched
//   d_done     : 1-cycle pulse, data access complete
//   d_rdata    : last load data, updated only when a load completes
//   mem_req    : memory request, held until mem_ready
//   mem_we     : memory write enable
//   mem_addr   : memory address
//   mem_wdata  : memory write data
//   mem_rdata  : memory read data, valid with mem_ready
//   mem_ready  : memory transaction completes on this edge
//   busy       : a transaction is outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_F = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_gnt_q,    if_gnt_d;
  logic                d_gnt_q,     d_gnt_d;
  logic                if_done_q,   if_done_d;
  logic                d_done_q,    d_done_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

  // Requesters eligible for a grant on this edge, and the arbitration result.
  logic cand_f, cand_d;
  logic win_f,  win_d;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    cand_f      = 1'b0;
    cand_d      = 1'b0;
    win_f       = 1'b0;
    win_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // mem_ready is ignored here: nothing is outstanding.
        cand_f = if_req;
        cand_d = d_req;
      end

      ST_BUSY_F: begin
        if (mem_ready) begin
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata;
          mem_req_d  = 1'b0;
          state_d    = ST_IDLE;
          // The fetch requester still holds if_req on its own completion
          // edge, so only the data side may be granted back-to-back.
          cand_d     = d_req;
        end
      end

      ST_BUSY_D: begin
        if (mem_ready) begin
          d_done_d  = 1'b1;
          // mem_we_q is the registered d_we of the access now completing;
          // stores leave d_rdata untouched.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          cand_f    = if_req;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Data wins a tie unless fetch has already been passed over too often.
    win_d = cand_d && (!cand_f || (streak_q != STREAK_MAX));
    win_f = cand_f && !win_d;

    if (win_d) begin
      state_d     = ST_BUSY_D;
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      d_gnt_d     = 1'b1;
      // Only grants that make a waiting fetch wait longer count toward the
      // streak; a data grant with no fetch pending restarts it.
      if (if_req) begin
        if (streak_q != STREAK_MAX) begin
          streak_d = streak_q + STREAK_W'(1);
        end
      end else begin
        streak_d = '0;
      end
    end

    if (win_f) begin
      state_d     = ST_BUSY_F;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      if_gnt_d    = 1'b1;
      streak_d    = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register. Reset abandons any in-flight access without a done pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Randomized bench: two requesters and a memory with random wait states drive
// the arbiter. A reference model, evaluated at every rising edge from the
// arbitration rules, pushes expected grants and completions into queues; a
// monitor a little after each edge pops and compares them against the DUT.
// STARVE_LIMIT is 1 so the tie-break override is reachable.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LIM = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct { int cyc; } gnt_t;
  typedef struct { int cyc; logic [DW-1:0] rdata; } done_t;

  gnt_t  gq_f[$];
  gnt_t  gq_d[$];
  done_t dq_f[$];
  done_t dq_d[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model state: owner 0 = none, 1 = fetch, 2 = data.
  int            m_owner  = 0;
  int            m_streak = 0;
  logic [AW-1:0] m_addr   = '0;
  logic          m_we     = 1'b0;
  logic [DW-1:0] m_wdata  = '0;
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_d_rdata  = '0;
  logic [DW-1:0] shadow  [256];
  logic [DW-1:0] env_mem [256];

  int n_f_done = 0;
  int n_d_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_mem_req"},   mem_req,   0);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_if_gnt"},    if_gnt,    0);
    check({tag, "_d_gnt"},     d_gnt,     0);
    check({tag, "_if_done"},   if_done,   0);
    check({tag, "_d_done"},    d_done,    0);
    check({tag, "_if_rdata"},  if_rdata,  0);
    check({tag, "_d_rdata"},   d_rdata,   0);
  endtask

  // Winner of one arbitration round: 0 none, 1 fetch, 2 data.
  function automatic int pick(input bit want_f, input bit want_d, input int streak);
    if (want_f && want_d) return (streak == LIM) ? 1 : 2;
    if (want_d) return 2;
    if (want_f) return 1;
    return 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: one evaluation per rising edge
  // ---------------------------------------------------------------------------
  initial begin
    bit want_f, want_d;
    int w;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        m_owner = 0; m_streak = 0; m_if_rdata = '0; m_d_rdata = '0;
        gq_f.delete(); gq_d.delete(); dq_f.delete(); dq_d.delete();
      end else begin
        want_f = 1'b0;
        want_d = 1'b0;
        if (m_owner == 0) begin
          want_f = if_req;
          want_d = d_req;
        end else if (mem_ready) begin
          if (m_owner == 1) begin
            m_if_rdata = shadow[m_addr[7:0]];
            dq_f.push_back('{cyc, m_if_rdata});
            want_d = d_req;
          end else begin
            if (m_we) shadow[m_addr[7:0]] = m_wdata;
            else      m_d_rdata = shadow[m_addr[7:0]];
            dq_d.push_back('{cyc, m_d_rdata});
            want_f = if_req;
          end
          m_owner = 0;
        end
        w = pick(want_f, want_d, m_streak);
        if (w == 2) begin
          m_owner = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
          m_streak = if_req ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
          gq_d.push_back('{cyc});
        end else if (w == 1) begin
          m_owner = 1; m_addr = if_addr; m_we = 1'b0; m_wdata = '0;
          m_streak = 0;
          gq_f.push_back('{cyc});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares DUT against expectations shortly after each edge
  // ---------------------------------------------------------------------------
  initial begin
    bit exp_p;
    done_t dn;
    forever begin
      @(posedge clk);
      #2;
      check("busy",     busy,     (m_owner != 0));
      check("mem_req",  mem_req,  (m_owner != 0));
      check("if_rdata", if_rdata, m_if_rdata);
      check("d_rdata",  d_rdata,  m_d_rdata);
      if (m_owner != 0) begin
        check("mem_addr",  mem_addr,  m_addr);
        check("mem_we",    mem_we,    m_we);
        check("mem_wdata", mem_wdata, m_wdata);
      end

      exp_p = (gq_f.size() > 0) && (gq_f[0].cyc == cyc);
      check("if_gnt", if_gnt, exp_p);
      if (exp_p) void'(gq_f.pop_front());

      exp_p = (gq_d.size() > 0) && (gq_d[0].cyc == cyc);
      check("d_gnt", d_gnt, exp_p);
      if (exp_p) void'(gq_d.pop_front());

      exp_p = (dq_f.size() > 0) && (dq_f[0].cyc == cyc);
      check("if_done", if_done, exp_p);
      if (exp_p) begin
        dn = dq_f.pop_front();
        check("if_done_rdata", if_rdata, dn.rdata);
        n_f_done++;
        $display("cyc %0d: fetch done, rdata=%04h", cyc, if_rdata);
      end

      exp_p = (dq_d.size() > 0) && (dq_d[0].cyc == cyc);
      check("d_done", d_done, exp_p);
      if (exp_p) begin
        dn = dq_d.pop_front();
        check("d_done_rdata", d_rdata, dn.rdata);
        n_d_done++;
        $display("cyc %0d: data done, d_rdata=%04h", cyc, d_rdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: requesters, memory with random waits, occasional reset
  // ---------------------------------------------------------------------------
  initial begin
    bit f_active = 1'b0;
    bit d_active = 1'b0;
    bit stim_on;
    int rst_cnt = 0;

    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 16'($urandom);
      shadow[i]  = env_mem[i];
    end

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("por");
    reset = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      stim_on = (c < 2700);

      // Fetch requester: hold until done, then drop or re-arm.
      if (f_active) begin
        if (if_done) begin
          if (stim_on && $urandom_range(1, 0) == 1) begin
            if_addr = 16'($urandom_range(255, 0));
          end else begin
            f_active = 1'b0;
            if_req   = 1'b0;
          end
        end
      end else if (stim_on && $urandom_range(99, 0) < 50) begin
        f_active = 1'b1;
        if_req   = 1'b1;
        if_addr  = 16'($urandom_range(255, 0));
      end

      // Data requester: same protocol, random load/store.
      if (d_active) begin
        if (d_done) begin
          if (stim_on && $urandom_range(1, 0) == 1) begin
            d_we    = 1'($urandom_range(1, 0));
            d_addr  = 16'($urandom_range(255, 0));
            d_wdata = 16'($urandom);
          end else begin
            d_active = 1'b0;
            d_req    = 1'b0;
          end
        end
      end else if (stim_on && $urandom_range(99, 0) < 50) begin
        d_active = 1'b1;
        d_req    = 1'b1;
        d_we     = 1'($urandom_range(1, 0));
        d_addr   = 16'($urandom_range(255, 0));
        d_wdata  = 16'($urandom);
      end

      // Memory: random wait states; stray mem_ready pulses while idle.
      if (mem_req) begin
        mem_ready = ($urandom_range(99, 0) < 40);
        if (mem_ready) begin
          mem_rdata = env_mem[mem_addr[7:0]];
          if (mem_we) env_mem[mem_addr[7:0]] = mem_wdata;
        end else begin
          mem_rdata = 16'($urandom);
        end
      end else begin
        mem_ready = ($urandom_range(9, 0) == 0);
        mem_rdata = 16'($urandom);
      end

      // Reset in the middle of a data access that is still waiting.
      if (rst_cnt < 3 && c > 600 * (rst_cnt + 1) && m_owner == 2 && !mem_ready) begin
        reset    = 1'b0;
        if_req   = 1'b0;
        d_req    = 1'b0;
        f_active = 1'b0;
        d_active = 1'b0;
        #1;
        check_all_zero("midrst");
        rst_cnt++;
        @(negedge clk);
        reset = 1'b1;
      end
    end

    check("queues_drained", gq_f.size() + gq_d.size() + dq_f.size() + dq_d.size(), 0);
    check("resets_injected", rst_cnt, 3);
    $display("fetch completions %0d, data completions %0d", n_f_done, n_d_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
